// File: rtl/vram_arb_pkg.sv
// Shared types and constants for the VRAM arbiter.
//   state_t  : arbiter FSM states (IDLE -> ACCESS -> DONE -> IDLE)
//   master_t : requesting master identity (CPU = req 0, GAME = req 1)
//   VRAM_DEPTH : number of valid VRAM words
package vram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    typedef enum logic {
        M_CPU,
        M_GAME
    } master_t;

    localparam int VRAM_DEPTH = 10;

endpackage

// File: rtl/vram_arb_pick.sv
// Combinational grant picker for the VRAM arbiter.
// Ports:
//   eligible[1:0] : bit 0 = CPU eligible, bit 1 = GAME eligible
//   last_grant    : master granted most recently
//   grant         : selected master (only meaningful when |eligible)
// Configuration macro: VRAM_ARB_RR_EN
//   defined   -> round-robin on contention (master not granted last wins)
//   undefined -> fixed priority, CPU wins every tie
module vram_arb_pick
    import vram_arb_pkg::*;
(
    input  logic [1:0] eligible,
    input  master_t    last_grant,
    output master_t    grant
);

`ifdef VRAM_ARB_RR_EN
    always_comb begin
        grant = M_CPU;
        if (eligible == 2'b11) begin
            grant = (last_grant == M_CPU) ? M_GAME : M_CPU;
        end else if (eligible[1]) begin
            grant = M_GAME;
        end
    end
`else
    // History is irrelevant under fixed priority.
    logic unused_last;
    assign unused_last = (last_grant == M_GAME);

    always_comb begin
        grant = M_CPU;
        if (!eligible[0] && eligible[1]) begin
            grant = M_GAME;
        end
    end
`endif

endmodule

// File: rtl/vram_arbiter.sv
// Two-master arbiter for the single-port VRAM (sync write, comb read).
// Serialises CPU (req 0) and GAME (req 1) accesses with a req/ack handshake,
// latches the winning request, and holds off writes while frame_lock is high.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   cpu_*  / game_*     : req, we, addr, wdata in; ack pulse and rdata out
//   frame_lock          : display sampling VRAM; no write may start
//   vram_we/addr/wdata  : VRAM write port / address
//   vram_rdata          : VRAM read data (combinational on vram_addr)
//   addr_err            : sticky out-of-range flag, cleared only by rst
// Configuration macro: VRAM_ARB_RR_EN (round-robin vs fixed CPU priority).
module vram_arbiter
    import vram_arb_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = VRAM_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              game_req,
    input  logic              game_we,
    input  logic [ADDR_W-1:0] game_addr,
    input  logic [DATA_W-1:0] game_wdata,
    output logic              game_ack,
    output logic [DATA_W-1:0] game_rdata,
    input  logic              frame_lock,
    output logic              vram_we,
    output logic [ADDR_W-1:0] vram_addr,
    output logic [DATA_W-1:0] vram_wdata,
    input  logic [DATA_W-1:0] vram_rdata,
    output logic              addr_err
);

    state_t            state, state_next;
    logic [1:0]        eligible;
    master_t           pick;
    master_t           last_grant;
    master_t           lat_id;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [DATA_W-1:0] rdata_q;
    logic              addr_err_q;
    logic              in_range;

    // A write is only eligible when the display is not sampling VRAM.
    assign eligible[0] = cpu_req  && !(cpu_we  && frame_lock);
    assign eligible[1] = game_req && !(game_we && frame_lock);
    assign in_range    = (lat_addr < ADDR_W'(DEPTH));

    vram_arb_pick u_pick (
        .eligible   (eligible),
        .last_grant (last_grant),
        .grant      (pick)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (|eligible) state_next = ACCESS;
            ACCESS:  state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Request latch, read capture and sticky error flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= M_GAME;
            lat_id     <= M_CPU;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            rdata_q    <= '0;
            addr_err_q <= 1'b0;
        end else begin
            if (state == IDLE && |eligible) begin
                last_grant <= pick;
                lat_id     <= pick;
                if (pick == M_CPU) begin
                    lat_we    <= cpu_we;
                    lat_addr  <= cpu_addr;
                    lat_wdata <= cpu_wdata;
                end else begin
                    lat_we    <= game_we;
                    lat_addr  <= game_addr;
                    lat_wdata <= game_wdata;
                end
            end
            if (state == ACCESS) begin
                rdata_q <= (!lat_we && in_range) ? vram_rdata : '0;
                if (!in_range) begin
                    addr_err_q <= 1'b1;
                end
            end
        end
    end

    // Outputs decoded from state so reset clears them immediately.
    always_comb begin
        vram_we    = 1'b0;
        vram_addr  = '0;
        vram_wdata = '0;
        cpu_ack    = 1'b0;
        cpu_rdata  = '0;
        game_ack   = 1'b0;
        game_rdata = '0;
        case (state)
            ACCESS: begin
                vram_we    = lat_we && in_range;
                vram_addr  = lat_addr;
                vram_wdata = lat_wdata;
            end
            DONE: begin
                if (lat_id == M_CPU) begin
                    cpu_ack   = 1'b1;
                    cpu_rdata = rdata_q;
                end else begin
                    game_ack   = 1'b1;
                    game_rdata = rdata_q;
                end
            end
            default: ;
        endcase
    end

    assign addr_err = addr_err_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed, scoreboard-based bench for vram_arbiter with a behavioural VRAM.
// Honours VRAM_ARB_RR_EN the same way as the design when predicting grant order.
module tb_vram_arbiter;
    import vram_arb_pkg::*;

    typedef struct packed {
        master_t     m;
        logic [31:0] d;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we, game_req, game_we, frame_lock;
    logic [31:0] cpu_addr, cpu_wdata, game_addr, game_wdata;
    logic        cpu_ack, game_ack, vram_we, addr_err;
    logic [31:0] cpu_rdata, game_rdata, vram_addr, vram_wdata, vram_rdata;

    logic [31:0] mem [0:15];

    int      n_cmp = 0;
    int      n_bad = 0;
    int      cyc = 0;
    int      ack_cyc = -1;
    int      c0;
    int      k;
    master_t w;
    master_t tb_last = M_GAME;
    exp_t    sb[$];

    always #5 clk = ~clk;

    vram_arbiter #(.DATA_W(32), .ADDR_W(32), .DEPTH(10)) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_ack    (cpu_ack),
        .cpu_rdata  (cpu_rdata),
        .game_req   (game_req),
        .game_we    (game_we),
        .game_addr  (game_addr),
        .game_wdata (game_wdata),
        .game_ack   (game_ack),
        .game_rdata (game_rdata),
        .frame_lock (frame_lock),
        .vram_we    (vram_we),
        .vram_addr  (vram_addr),
        .vram_wdata (vram_wdata),
        .vram_rdata (vram_rdata),
        .addr_err   (addr_err)
    );

    // Behavioural VRAM: 10 valid words, sync write, comb read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) mem[i] <= '0;
        end else if (vram_we && vram_addr < 32'd10) begin
            mem[vram_addr[3:0]] <= vram_wdata;
        end
    end
    assign vram_rdata = (vram_addr < 32'd10) ? mem[vram_addr[3:0]] : '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
        end
    endtask

    // Pops the scoreboard on every ack and drops the acked master's request.
    task automatic observe();
        exp_t e;
        if (cpu_ack || game_ack) begin
            ack_cyc = cyc;
            if (sb.size() == 0) begin
                chk("unexpected_ack", {62'd0, cpu_ack, game_ack}, 64'd0);
            end else begin
                e = sb.pop_front();
                chk("ack_owner", {62'd0, cpu_ack, game_ack},
                    (e.m == M_CPU) ? 64'd2 : 64'd1);
                if (e.m == M_CPU) begin
                    chk("cpu_rdata", {32'd0, cpu_rdata}, {32'd0, e.d});
                    chk("game_rdata_idle", {32'd0, game_rdata}, 64'd0);
                    cpu_req = 1'b0;
                end else begin
                    chk("game_rdata", {32'd0, game_rdata}, {32'd0, e.d});
                    chk("cpu_rdata_idle", {32'd0, cpu_rdata}, 64'd0);
                    game_req = 1'b0;
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        observe();
    endtask

    task automatic drain(input int maxc);
        int n = 0;
        while (sb.size() > 0 && n < maxc) begin
            tick();
            n++;
        end
        if (sb.size() != 0) begin
            chk("drain_timeout", 64'(sb.size()), 64'd0);
            sb.delete();
        end
        cpu_req  = 1'b0;
        game_req = 1'b0;
        tick();
    endtask

    task automatic cpu_go(input logic we, input logic [31:0] a, input logic [31:0] d);
        cpu_we = we; cpu_addr = a; cpu_wdata = d; cpu_req = 1'b1;
    endtask

    task automatic game_go(input logic we, input logic [31:0] a, input logic [31:0] d);
        game_we = we; game_addr = a; game_wdata = d; game_req = 1'b1;
    endtask

    task automatic expect_ack(input master_t m, input logic [31:0] d);
        sb.push_back('{m: m, d: d});
    endtask

    function automatic master_t other(input master_t m);
        return (m == M_CPU) ? M_GAME : M_CPU;
    endfunction

    function automatic master_t tie_winner();
`ifdef VRAM_ARB_RR_EN
        return other(tb_last);
`else
        return M_CPU;
`endif
    endfunction

    function automatic logic [31:0] rd_of(input master_t m);
        return (m == M_CPU) ? 32'h22 : 32'h77;
    endfunction

    initial begin
        rst = 1'b1;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        game_req = 0; game_we = 0; game_addr = '0; game_wdata = '0;
        frame_lock = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_vram_we",    {63'd0, vram_we}, 64'd0);
        chk("rst_vram_addr",  {32'd0, vram_addr}, 64'd0);
        chk("rst_vram_wdata", {32'd0, vram_wdata}, 64'd0);
        chk("rst_acks",       {62'd0, cpu_ack, game_ack}, 64'd0);
        chk("rst_cpu_rdata",  {32'd0, cpu_rdata}, 64'd0);
        chk("rst_game_rdata", {32'd0, game_rdata}, 64'd0);
        chk("rst_addr_err",   {63'd0, addr_err}, 64'd0);
        rst = 1'b0;
        tick();

        // T1: CPU write addr 1
        cpu_go(1'b1, 32'd1, 32'hFA32);
        expect_ack(M_CPU, 32'h0);
        tb_last = M_CPU;
        c0 = cyc;
        tick();
        chk("t1_access_we",    {63'd0, vram_we}, 64'd1);
        chk("t1_access_addr",  {32'd0, vram_addr}, 64'd1);
        chk("t1_access_wdata", {32'd0, vram_wdata}, 64'hFA32);
        chk("t1_no_early_ack", {63'd0, cpu_ack}, 64'd0);
        tick();
        chk("t1_done_we",  {63'd0, vram_we}, 64'd0);
        chk("t1_latency",  64'(ack_cyc - c0), 64'd2);
        drain(10);
        chk("t1_idle_we",  {63'd0, vram_we}, 64'd0);

        // T2: CPU read back addr 1
        cpu_go(1'b0, 32'd1, 32'h0);
        expect_ack(M_CPU, 32'hFA32);
        drain(10);

        // Preload data used by the contention and frame_lock tests
        cpu_go(1'b1, 32'd2, 32'h22);  expect_ack(M_CPU, 32'h0);  drain(10);
        game_go(1'b1, 32'd7, 32'h77); expect_ack(M_GAME, 32'h0); drain(10);
        cpu_go(1'b1, 32'd3, 32'h33);  expect_ack(M_CPU, 32'h0);  drain(10);
        tb_last = M_CPU;

        // T3: simultaneous reads, four rounds
        for (int r = 0; r < 4; r++) begin
            w = tie_winner();
            cpu_go(1'b0, 32'd2, 32'h0);
            game_go(1'b0, 32'd7, 32'h0);
            expect_ack(w, rd_of(w));
            expect_ack(other(w), rd_of(other(w)));
            tb_last = other(w);
            drain(20);
        end

        // T3b: tie winner re-requests at once while the loser still waits
        w = tie_winner();
        cpu_go(1'b0, 32'd2, 32'h0);
        game_go(1'b0, 32'd7, 32'h0);
`ifdef VRAM_ARB_RR_EN
        expect_ack(w, rd_of(w));
        expect_ack(other(w), rd_of(other(w)));
        expect_ack(w, rd_of(w));
        tb_last = w;
`else
        expect_ack(M_CPU, 32'h22);
        expect_ack(M_CPU, 32'h22);
        expect_ack(M_GAME, 32'h77);
        tb_last = M_GAME;
`endif
        k = 0;
        while (sb.size() == 3 && k < 10) begin
            tick();
            k++;
        end
        if (w == M_CPU) cpu_req = 1'b1;
        else            game_req = 1'b1;
        drain(30);

        // T4: GAME write blocked by frame_lock, CPU read proceeds
        frame_lock = 1'b1;
        game_go(1'b1, 32'd5, 32'hEA99);
        cpu_go(1'b0, 32'd3, 32'h0);
        expect_ack(M_CPU, 32'h33);
        expect_ack(M_GAME, 32'h0);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("t4_locked_no_we", {63'd0, vram_we}, 64'd0);
        end
        chk("t4_game_pending", 64'(sb.size()), 64'd1);
        frame_lock = 1'b0;
        tick();
        chk("t4_game_we",   {63'd0, vram_we}, 64'd1);
        chk("t4_game_addr", {32'd0, vram_addr}, 64'd5);
        drain(10);
        tb_last = M_GAME;
        cpu_go(1'b0, 32'd5, 32'h0);
        expect_ack(M_CPU, 32'hEA99);
        drain(10);

        // T5: out-of-range write
        chk("t5_err_before", {63'd0, addr_err}, 64'd0);
        cpu_go(1'b1, 32'd12, 32'hBAD);
        expect_ack(M_CPU, 32'h0);
        tick();
        chk("t5_no_we", {63'd0, vram_we}, 64'd0);
        drain(10);
        chk("t5_err_set", {63'd0, addr_err}, 64'd1);
        cpu_go(1'b0, 32'd1, 32'h0);
        expect_ack(M_CPU, 32'hFA32);
        drain(10);
        chk("t5_err_sticky", {63'd0, addr_err}, 64'd1);

        // T6: reset during the ACCESS cycle of a write
        cpu_go(1'b1, 32'd4, 32'h44);
        tick();
        chk("t6_access_we", {63'd0, vram_we}, 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_we",       {63'd0, vram_we}, 64'd0);
        chk("t6_rst_addr",     {32'd0, vram_addr}, 64'd0);
        chk("t6_rst_cpu_ack",  {63'd0, cpu_ack}, 64'd0);
        chk("t6_rst_rdata",    {32'd0, cpu_rdata}, 64'd0);
        chk("t6_rst_addr_err", {63'd0, addr_err}, 64'd0);
        cpu_req = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        tick();
        chk("t6_post_ack", {62'd0, cpu_ack, game_ack}, 64'd0);
        chk("t6_post_we",  {63'd0, vram_we}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
